// File: rtl/md_unit_if.sv
// Handshake and result bus between the E-stage issue logic and the
// multiply/divide unit.
interface md_unit_if;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, md_op, A, B,
        input  busy, HI, LO
    );

    modport slave (
        input  start, md_op, A, B,
        output busy, HI, LO
    );
endinterface

// File: rtl/md_unit.sv
// Fixed-latency multiply/divide unit owning the HI/LO pair.
// Operands are latched at accept; the result is produced on the last busy edge.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    logic [0:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       op_reg, op_next;
    logic [31:0]      a_reg, a_next;
    logic [31:0]      b_reg, b_next;
    logic [31:0]      hi_reg, hi_next;
    logic [31:0]      lo_reg, lo_next;

    logic [63:0] acc;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag, b_mag, b_safe;
    logic [31:0] q_mag, r_mag;
    logic [31:0] sq, sr, uq, ur;
    logic        b_zero;
    logic [31:0] res_hi, res_lo;
    logic        res_we;

    assign md.busy = (state_reg == ST_BUSY);
    assign md.HI   = hi_reg;
    assign md.LO   = lo_reg;

    // Result datapath works purely from latched operands and the current HI/LO.
    always_comb begin
        acc    = {hi_reg, lo_reg};
        prod_s = {{32{a_reg[31]}}, a_reg} * {{32{b_reg[31]}}, b_reg};
        prod_u = {32'd0, a_reg} * {32'd0, b_reg};
        b_zero = (b_reg == 32'd0);
        b_safe = b_zero ? 32'd1 : b_reg;

        // Signed division on magnitudes so 0x80000000 / -1 needs no special case.
        a_mag = a_reg[31] ? (~a_reg + 32'd1) : a_reg;
        b_mag = b_reg[31] ? (~b_reg + 32'd1) : b_safe;
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        sq    = (a_reg[31] ^ b_reg[31]) ? (~q_mag + 32'd1) : q_mag;
        sr    = a_reg[31] ? (~r_mag + 32'd1) : r_mag;
        uq    = a_reg / b_safe;
        ur    = a_reg % b_safe;

        res_hi = hi_reg;
        res_lo = lo_reg;
        res_we = 1'b0;
        case (op_reg)
            OP_MULT:  begin {res_hi, res_lo} = prod_s;       res_we = 1'b1; end
            OP_MULTU: begin {res_hi, res_lo} = prod_u;       res_we = 1'b1; end
            OP_MADD:  begin {res_hi, res_lo} = acc + prod_s; res_we = 1'b1; end
            OP_MADDU: begin {res_hi, res_lo} = acc + prod_u; res_we = 1'b1; end
            OP_MSUB:  begin {res_hi, res_lo} = acc - prod_s; res_we = 1'b1; end
            OP_MSUBU: begin {res_hi, res_lo} = acc - prod_u; res_we = 1'b1; end
            OP_DIV:   begin res_hi = sr; res_lo = sq; res_we = !b_zero; end
            OP_DIVU:  begin res_hi = ur; res_lo = uq; res_we = !b_zero; end
            default:  res_we = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;

        if (state_reg == ST_IDLE) begin
            if (md.start) begin
                case (md.md_op)
                    OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                        state_next = ST_BUSY;
                        cnt_next   = MULT_N;
                        op_next    = md.md_op;
                        a_next     = md.A;
                        b_next     = md.B;
                    end
                    OP_DIV, OP_DIVU: begin
                        state_next = ST_BUSY;
                        cnt_next   = DIV_N;
                        op_next    = md.md_op;
                        a_next     = md.A;
                        b_next     = md.B;
                    end
                    OP_MTHI: hi_next = md.A;
                    OP_MTLO: lo_next = md.A;
                    default: ;
                endcase
            end
        end else begin
            // start is deliberately ignored here; the hazard logic keeps it low.
            if (cnt_reg <= CNT_ONE) begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                if (res_we) begin
                    hi_next = res_hi;
                    lo_next = res_lo;
                end
            end else begin
                cnt_next = cnt_reg - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= 4'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: the driver queues expected HI/LO and busy length,
// a monitor pops and compares on every busy falling edge.
module tb_md_unit;

    logic clk = 1'b0;
    logic reset;

    md_unit_if bus();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reset as sampled by the DUT on the most recent rising edge.
    logic rst_q = 1'b1;
    always @(posedge clk) rst_q <= reset;

    logic        prev_busy = 1'b0;
    int          run_len   = 0;
    logic [31:0] held_hi, held_lo;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1) begin
                run_len++;
                if (!prev_busy) begin
                    held_hi = bus.HI;
                    held_lo = bus.LO;
                end else begin
                    check32("hold_hi", bus.HI, held_hi);
                    check32("hold_lo", bus.LO, held_lo);
                end
            end else if (prev_busy) begin
                if (!rst_q) begin
                    $display("abort  after %0d busy cycles (reset)", run_len);
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got HI=%h LO=%h, expected no completion", bus.HI, bus.LO);
                end else begin
                    e = exp_q.pop_front();
                    check32({e.name, "_hi"}, bus.HI, e.hi);
                    check32({e.name, "_lo"}, bus.LO, e.lo);
                    check32({e.name, "_busy_len"}, 32'(run_len), 32'(e.len));
                    $display("done   %-10s HI=%h LO=%h busy=%0d", e.name, bus.HI, bus.LO, run_len);
                end
                run_len = 0;
            end
            prev_busy = (bus.busy === 1'b1);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=%b after %0d cycles, expected 0", bus.busy, n);
        end
    endtask

    // Drives one start pulse; elen>0 queues a multi-cycle expectation.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string name, input logic [31:0] ehi, input logic [31:0] elo,
                         input int elen);
        exp_t e;
        wait_idle();
        bus.start = 1'b1;
        bus.md_op = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.md_op = 4'd0;
        bus.A     = 32'hA5A5_5A5A;
        bus.B     = 32'h0F0F_F0F0;
        $display("issue  %-10s op=%0d A=%h B=%h", name, op, a, b);
        if (elen > 0) begin
            e.hi = ehi; e.lo = elo; e.len = elen; e.name = name;
            exp_q.push_back(e);
            check32({name, "_busy_rise"}, {31'd0, bus.busy}, 32'd1);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        exp_t e;
        int   n;
        bus.start = 1'b0;
        bus.md_op = 4'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        reset     = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check32("reset_hi", bus.HI, 32'd0);
        check32("reset_lo", bus.LO, 32'd0);
        check32("reset_busy", {31'd0, bus.busy}, 32'd0);

        issue(4'd1, 32'hFFFF_FFFF, 32'd2, "mult",  32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
        issue(4'd2, 32'hFFFF_FFFF, 32'd2, "multu", 32'h0000_0001, 32'hFFFF_FFFE, 5);
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, "div",   32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(4'd4, 32'd7,         32'd0, "divu_b0", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 32'h0, 32'h8000_0000, 10);
        issue(4'd4, 32'hFFFF_FFFF, 32'h10, "divu", 32'h0000_000F, 32'h0FFF_FFFF, 10);
        issue(4'd3, 32'd7, 32'hFFFF_FFFE, "div_negb", 32'h0000_0001, 32'hFFFF_FFFD, 10);

        issue(4'd9, 32'h1234_5678, 32'd0, "mthi", 32'd0, 32'd0, 0);
        check32("mthi_hi", bus.HI, 32'h1234_5678);
        check32("mthi_lo", bus.LO, 32'hFFFF_FFFD);
        check32("mthi_busy", {31'd0, bus.busy}, 32'd0);
        issue(4'd10, 32'h0, 32'd0, "mtlo", 32'd0, 32'd0, 0);
        check32("mtlo_hi", bus.HI, 32'h1234_5678);
        check32("mtlo_lo", bus.LO, 32'h0);

        issue(4'd5, 32'd3,   32'd4, "madd",  32'h1234_5678, 32'h0000_000C, 5);
        issue(4'd8, 32'hD,   32'd1, "msubu", 32'h1234_5677, 32'hFFFF_FFFF, 5);
        issue(4'd7, 32'd2,   32'hFFFF_FFFF, "msub", 32'h1234_5678, 32'h0000_0001, 5);
        issue(4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "maddu", 32'h1234_5676, 32'h0000_0002, 5);

        issue(4'd0,  32'hDEAD_BEEF, 32'd3, "op_none", 32'd0, 32'd0, 0);
        issue(4'd11, 32'hDEAD_BEEF, 32'd3, "op_11",   32'd0, 32'd0, 0);
        issue(4'd15, 32'hDEAD_BEEF, 32'd3, "op_15",   32'd0, 32'd0, 0);
        check32("noop_busy", {31'd0, bus.busy}, 32'd0);
        check32("noop_hi", bus.HI, 32'h1234_5676);
        check32("noop_lo", bus.LO, 32'h0000_0002);

        // mult with an mtlo attempt on its second busy cycle.
        wait_idle();
        bus.start = 1'b1; bus.md_op = 4'd1; bus.A = 32'hFFFF_FFFD; bus.B = 32'h100;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.md_op = 4'd0;
        e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FD00; e.len = 5; e.name = "mult_ign";
        exp_q.push_back(e);
        $display("issue  mult_ign   op=1 A=fffffffd B=00000100");
        @(posedge clk); #1;
        bus.start = 1'b1; bus.md_op = 4'd10; bus.A = 32'h0000_DEAD;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.md_op = 4'd0;

        // div aborted by reset in its third busy cycle.
        wait_idle();
        bus.start = 1'b1; bus.md_op = 4'd3; bus.A = 32'd100; bus.B = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.md_op = 4'd0;
        $display("issue  div_abort  op=3 A=00000064 B=00000007");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check32("abort_busy", {31'd0, bus.busy}, 32'd0);
        check32("abort_hi", bus.HI, 32'd0);
        check32("abort_lo", bus.LO, 32'd0);

        issue(4'd1, 32'd6, 32'd7, "mult_post", 32'h0, 32'h0000_002A, 5);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending completions, expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
